// File: rtl/neuron_mac_seq_if.sv
// Bus between the neuron MAC engine and its surroundings.
// The surroundings are the weight ROM, the input-sample buffer, the start source and the result consumer.
interface neuron_mac_seq_if #(
    parameter int ACC_W = 20
);
    logic             start;
    logic [7:0]       w_addr;
    logic             w_en;
    logic [7:0]       w_data;
    logic [7:0]       x_addr;
    logic [7:0]       x_data;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] y_acc;
    logic [7:0]       y_out;

    modport master (
        output start, w_data, x_data,
        input  w_addr, w_en, x_addr, busy, done, y_acc, y_out
    );

    modport slave (
        input  start, w_data, x_data,
        output w_addr, w_en, x_addr, busy, done, y_acc, y_out
    );
endinterface

// File: rtl/neuron_mac_seq.sv
// Sequential MAC for one neuron: walks the weight ROM and the input buffer, accumulates w*x,
// then presents the raw sum and a shifted, saturated 8-bit activation.
//
// state  | meaning
// IDLE   | waiting for start, ROM bus released, results held
// RUN    | one weight/input pair per cycle, ROM enabled
// DONE   | results valid, done pulse, ROM released
module neuron_mac_seq #(
    parameter int N_INPUTS    = 4,
    parameter int WEIGHT_BASE = 0,
    parameter int ACC_W       = 20,
    parameter int SHIFT       = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    neuron_mac_seq_if.slave    bus
);
    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_y_acc;
    logic [7:0]         r_y_out;

    logic [15:0]        w_prod;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [ACC_W-1:0]   w_shifted;
    logic [7:0]         w_sat;
    logic               w_last;
    logic               w_run;

    assign w_run     = (r_state == S_RUN);
    assign w_last    = (r_idx == IDX_W'(N_INPUTS - 1));
    assign w_prod    = 16'(bus.w_data) * 16'(bus.x_data);
    assign w_acc_nxt = r_acc + ACC_W'(w_prod);
    assign w_shifted = w_acc_nxt >> SHIFT;
    assign w_sat     = (|w_shifted[ACC_W-1:8]) ? 8'hFF : w_shifted[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Results are captured on the edge entering DONE so they appear together with the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_acc   <= '0;
            r_y_acc <= '0;
            r_y_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_idx <= '0;
                        r_acc <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nxt;
                    if (w_last) begin
                        r_y_acc <= w_acc_nxt;
                        r_y_out <= w_sat;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The ROM bus is shared, so enable and address are decoded straight from the state register
    // and collapse asynchronously with reset.
    assign bus.w_en   = w_run;
    assign bus.w_addr = w_run ? (8'(WEIGHT_BASE) + 8'(r_idx)) : 8'h00;
    assign bus.x_addr = 8'(r_idx);
    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = (r_state == S_DONE);
    assign bus.y_acc  = r_y_acc;
    assign bus.y_out  = r_y_out;
endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq: several parameter variants share one stimulus stream.
module tb_neuron_mac_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic [7:0] x_mem [4];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    neuron_mac_seq_if #(.ACC_W(20)) if0   ();
    neuron_mac_seq_if #(.ACC_W(20)) if2   ();
    neuron_mac_seq_if #(.ACC_W(20)) if126 ();
    neuron_mac_seq_if #(.ACC_W(20)) if254 ();
    neuron_mac_seq_if #(.ACC_W(20)) if1   ();

    neuron_mac_seq #(.N_INPUTS(4), .WEIGHT_BASE(0),   .ACC_W(20), .SHIFT(0)) u_d0   (.clk(clk), .rst_n(rst_n), .bus(if0));
    neuron_mac_seq #(.N_INPUTS(4), .WEIGHT_BASE(0),   .ACC_W(20), .SHIFT(2)) u_d2   (.clk(clk), .rst_n(rst_n), .bus(if2));
    neuron_mac_seq #(.N_INPUTS(4), .WEIGHT_BASE(126), .ACC_W(20), .SHIFT(0)) u_d126 (.clk(clk), .rst_n(rst_n), .bus(if126));
    neuron_mac_seq #(.N_INPUTS(4), .WEIGHT_BASE(254), .ACC_W(20), .SHIFT(0)) u_d254 (.clk(clk), .rst_n(rst_n), .bus(if254));
    neuron_mac_seq #(.N_INPUTS(1), .WEIGHT_BASE(0),   .ACC_W(20), .SHIFT(0)) u_d1   (.clk(clk), .rst_n(rst_n), .bus(if1));

    // Weight ROM image: this neuron's weights are 1,3,2,5 starting at its base address.
    function automatic logic [7:0] rom(input logic [7:0] base, input logic [7:0] addr, input logic en);
        logic [7:0] off;
        off = addr - base;
        if (!en) return 8'h00;
        case (off)
            8'd0:    return 8'd1;
            8'd1:    return 8'd3;
            8'd2:    return 8'd2;
            8'd3:    return 8'd5;
            default: return 8'h00;
        endcase
    endfunction

    assign if0.start   = start;
    assign if2.start   = start;
    assign if126.start = start;
    assign if254.start = start;
    assign if1.start   = start;
    assign if0.w_data   = rom(8'd0,   if0.w_addr,   if0.w_en);
    assign if2.w_data   = rom(8'd0,   if2.w_addr,   if2.w_en);
    assign if126.w_data = rom(8'd126, if126.w_addr, if126.w_en);
    assign if254.w_data = rom(8'd254, if254.w_addr, if254.w_en);
    assign if1.w_data   = rom(8'd0,   if1.w_addr,   if1.w_en);
    assign if0.x_data   = x_mem[if0.x_addr[1:0]];
    assign if2.x_data   = x_mem[if2.x_addr[1:0]];
    assign if126.x_data = x_mem[if126.x_addr[1:0]];
    assign if254.x_data = x_mem[if254.x_addr[1:0]];
    assign if1.x_data   = x_mem[if1.x_addr[1:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One evaluation from a start pulse; expected values are passed in by the caller.
    task automatic run_eval(input logic [31:0] e_acc, input logic [31:0] e_y0, input logic [31:0] e_y2,
                            input logic [31:0] e_n1acc);
        logic [7:0]  e126 [4];
        logic [7:0]  e254 [4];
        logic [19:0] prev;
        e126 = '{8'd126, 8'd127, 8'd128, 8'd129};
        e254 = '{8'd254, 8'd255, 8'd0, 8'd1};
        prev = if0.y_acc;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("run_w_en",      {31'd0, if0.w_en},      32'd1);
            chk("run_busy",      {31'd0, if0.busy},      32'd1);
            chk("run_done",      {31'd0, if0.done},      32'd0);
            chk("run_w_addr0",   {24'd0, if0.w_addr},    k);
            chk("run_w_addr126", {24'd0, if126.w_addr},  {24'd0, e126[k]});
            chk("run_w_addr254", {24'd0, if254.w_addr},  {24'd0, e254[k]});
            chk("run_x_addr126", {24'd0, if126.x_addr},  k);
            if (k == 1) begin
                chk("n1_done",  {31'd0, if1.done}, 32'd1);
                chk("n1_y_acc", {12'd0, if1.y_acc}, e_n1acc);
                chk("n1_w_en",  {31'd0, if1.w_en}, 32'd0);
            end
            if (k == 2) chk("y_acc_held", {12'd0, if0.y_acc}, {12'd0, prev});
            @(negedge clk);
        end
        chk("done_pulse",  {31'd0, if0.done},   32'd1);
        chk("done_w_en",   {31'd0, if0.w_en},   32'd0);
        chk("y_acc0",      {12'd0, if0.y_acc},  e_acc);
        chk("y_out0",      {24'd0, if0.y_out},  e_y0);
        chk("y_acc2",      {12'd0, if2.y_acc},  e_acc);
        chk("y_out2",      {24'd0, if2.y_out},  e_y2);
        chk("y_acc126",    {12'd0, if126.y_acc}, e_acc);
        chk("y_acc254",    {12'd0, if254.y_acc}, e_acc);
        @(negedge clk);
        chk("after_done",  {31'd0, if0.done},   32'd0);
        chk("after_busy",  {31'd0, if0.busy},   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        int n_done;
        int n_idle;
        int first_done;
        x_mem = '{8'd10, 8'd20, 8'd30, 8'd40};

        // Reset and quiet idle
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_w_en",  {31'd0, if0.w_en},  32'd0);
        chk("rst_y_acc", {12'd0, if0.y_acc}, 32'd0);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if0.w_en || if0.busy || if0.done || if0.y_acc != 0 || if0.y_out != 0 ||
                if0.w_addr != 0 || if0.x_addr != 0 || if254.w_en || if1.w_en) bad++;
        end
        chk("idle_quiet", bad, 32'd0);

        // 330 saturates to 255 unshifted; 330>>2 = 82; N_INPUTS=1 gives 1*10
        run_eval(32'd330, 32'd255, 32'd82, 32'd10);

        // Only the last sample nonzero: 5*1
        x_mem = '{8'd0, 8'd0, 8'd0, 8'd1};
        run_eval(32'd5, 32'd5, 32'd1, 32'd0);

        // start held high: evaluations every N_INPUTS+2 cycles
        @(negedge clk) start = 1'b1;
        n_done = 0; n_idle = 0; first_done = 0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (if0.done) begin
                n_done++;
                if (first_done == 0) first_done = k;
            end
            if (!if0.busy) n_idle++;
        end
        start = 1'b0;
        chk("held_done_cnt",   n_done,     32'd3);
        chk("held_idle_cnt",   n_idle,     32'd3);
        chk("held_first_done", first_done, 32'd5);

        // start pulses during RUN and DONE are dropped
        @(negedge clk);
        @(negedge clk) start = 1'b1;
        n_done = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (if0.done) n_done++;
            start = (k == 2 || k == 5);
        end
        start = 1'b0;
        chk("ignored_start", n_done, 32'd1);

        // Reset in the third RUN cycle
        x_mem = '{8'd10, 8'd20, 8'd30, 8'd40};
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_w_en", {31'd0, if0.w_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_w_en",  {31'd0, if0.w_en},  32'd0);
        chk("midrst_busy",  {31'd0, if0.busy},  32'd0);
        chk("midrst_y_acc", {12'd0, if0.y_acc}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (if0.done || if0.busy) n_done++;
        end
        chk("post_rst_quiet", n_done, 32'd0);
        chk("post_rst_y_acc", {12'd0, if0.y_acc}, 32'd0);

        run_eval(32'd330, 32'd255, 32'd82, 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
